// File: rtl/matmul_gesture_sched_pkg.sv
// Shared types and sizing constants for the gesture-classifier scheduler.
package matmul_gesture_sched_pkg;

  localparam int NUM_GESTURES = 4;
  localparam int NUM_PIXELS   = 64;
  localparam int PIXEL_ADDR_W = 6;
  localparam int GESTURE_W    = 2;
  // One counter covers {gesture, pixel}; it wraps to zero after the last pixel of the last gesture.
  localparam int SEQ_CNT_W    = GESTURE_W + PIXEL_ADDR_W;

  typedef enum logic [GESTURE_W-1:0] {
    GESTURE_UP    = 2'd0,
    GESTURE_DOWN  = 2'd1,
    GESTURE_LEFT  = 2'd2,
    GESTURE_RIGHT = 2'd3
  } gesture_e;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/matmul_gesture_sched_if.sv
// Bundle of the start handshake, weight-ROM / frame-buffer read port and result handshake.
// The master side is the scheduler; the slave side is the surrounding system.
interface matmul_gesture_sched_if #(
  parameter int COUNTER_WIDTH_P = 8,
  parameter int PIXEL_WIDTH_P   = 8,
  parameter int ACC_WIDTH_P     = 20
);

  logic                                               start_v_i;
  logic                                               start_ready_o;
  logic [matmul_gesture_sched_pkg::GESTURE_W-1:0]     gesture_o;
  logic [matmul_gesture_sched_pkg::PIXEL_ADDR_W-1:0]  pixel_addr_o;
  logic signed [COUNTER_WIDTH_P-1:0]                  weight_i;
  logic [PIXEL_WIDTH_P-1:0]                           pixel_i;
  logic                                               frame_busy_o;
  logic                                               result_v_o;
  logic                                               result_ready_i;
  logic [matmul_gesture_sched_pkg::GESTURE_W-1:0]     gesture_o_best;
  logic signed [ACC_WIDTH_P-1:0]                      score_o;

  modport master (
    input  start_v_i, weight_i, pixel_i, result_ready_i,
    output start_ready_o, gesture_o, pixel_addr_o, frame_busy_o,
           result_v_o, gesture_o_best, score_o
  );

  modport slave (
    output start_v_i, weight_i, pixel_i, result_ready_i,
    input  start_ready_o, gesture_o, pixel_addr_o, frame_busy_o,
           result_v_o, gesture_o_best, score_o
  );

endinterface

// File: rtl/matmul_gesture_sched_mac_acc.sv
// Signed multiply-accumulate for one gesture dot product. The first pixel of a
// gesture loads the product instead of adding, so no separate clear cycle is needed.
// final_o is the sum including the current cycle's product (used for the argmax).
module matmul_gesture_sched_mac_acc #(
  parameter int COUNTER_WIDTH_P = 8,
  parameter int PIXEL_WIDTH_P   = 8,
  parameter int ACC_WIDTH_P     = 20
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic                              first_i,
  input  logic signed [COUNTER_WIDTH_P-1:0] weight_i,
  input  logic [PIXEL_WIDTH_P-1:0]          pixel_i,
  output logic signed [ACC_WIDTH_P-1:0]     final_o
);

  logic signed [ACC_WIDTH_P-1:0] weight_ext_s;
  logic signed [ACC_WIDTH_P-1:0] pixel_ext_s;
  logic signed [ACC_WIDTH_P-1:0] prod_s;
  logic signed [ACC_WIDTH_P-1:0] acc_q;
  logic signed [ACC_WIDTH_P-1:0] acc_d;

  // Extend operands (weight sign-extended, pixel zero-extended), multiply and form the next sum.
  always_comb begin
    weight_ext_s = ACC_WIDTH_P'(weight_i);
    pixel_ext_s  = signed'(ACC_WIDTH_P'(pixel_i));
    prod_s       = weight_ext_s * pixel_ext_s;
    if (first_i) begin
      acc_d = prod_s;
    end else begin
      acc_d = acc_q + prod_s;
    end
  end

  assign final_o = acc_d;

  // Accumulator register, advanced only while the scheduler is walking pixels.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end else begin
      acc_q <= acc_q;
    end
  end

endmodule

// File: rtl/matmul_gesture_sched.sv
// Gesture-classifier sequencer: on an accepted start it walks 4 gestures x 64 pixels,
// addresses the weight ROM and frame buffer, accumulates each dot product and keeps
// the best-scoring gesture, then offers it on a valid/ready result port.
module matmul_gesture_sched
  import matmul_gesture_sched_pkg::*;
#(
  parameter int WIDTH_P         = 8,
  parameter int HEIGHT_P        = 8,
  parameter int COUNTER_WIDTH_P = 8,
  parameter int PIXEL_WIDTH_P   = 8,
  parameter int ACC_WIDTH_P     = 20
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  matmul_gesture_sched_if.master bus_if
);

  localparam int FRAME_PIXELS_LP = WIDTH_P * HEIGHT_P;

  sched_state_e                  state_q;
  logic [SEQ_CNT_W-1:0]          cnt_q;
  logic [SEQ_CNT_W-1:0]          cnt_d;
  logic                          start_ready_q;
  logic                          frame_busy_q;
  logic                          result_v_q;
  gesture_e                      best_q;
  logic signed [ACC_WIDTH_P-1:0] score_q;

  logic signed [ACC_WIDTH_P-1:0] final_s;
  logic [GESTURE_W-1:0]          gesture_s;
  logic [PIXEL_ADDR_W-1:0]       pixel_s;
  logic                          run_s;
  logic                          first_pixel_s;
  logic                          last_pixel_s;
  logic                          last_gesture_s;
  logic                          take_best_s;

  // Decode the {gesture, pixel} counter and decide whether this gesture becomes the new best.
  always_comb begin
    gesture_s      = cnt_q[SEQ_CNT_W-1 -: GESTURE_W];
    pixel_s        = cnt_q[PIXEL_ADDR_W-1:0];
    run_s          = (state_q == SCHED_RUN);
    first_pixel_s  = (pixel_s == {PIXEL_ADDR_W{1'b0}});
    last_pixel_s   = (pixel_s == PIXEL_ADDR_W'(FRAME_PIXELS_LP - 1));
    last_gesture_s = (gesture_s == GESTURE_W'(NUM_GESTURES - 1));
    // Gesture 0 always seeds the best; later gestures need a strictly higher score so ties keep the lower index.
    take_best_s    = run_s && last_pixel_s &&
                     ((gesture_s == {GESTURE_W{1'b0}}) || (final_s > score_q));
    cnt_d          = cnt_q + {{(SEQ_CNT_W-1){1'b0}}, 1'b1};
  end

  matmul_gesture_sched_mac_acc #(
    .COUNTER_WIDTH_P (COUNTER_WIDTH_P),
    .PIXEL_WIDTH_P   (PIXEL_WIDTH_P),
    .ACC_WIDTH_P     (ACC_WIDTH_P)
  ) u_mac_acc (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (run_s),
    .first_i  (first_pixel_s),
    .weight_i (bus_if.weight_i),
    .pixel_i  (bus_if.pixel_i),
    .final_o  (final_s)
  );

  // Scheduler FSM with registered handshake outputs, sequence counter and argmax registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= SCHED_IDLE;
      cnt_q         <= {SEQ_CNT_W{1'b0}};
      start_ready_q <= 1'b1;
      frame_busy_q  <= 1'b0;
      result_v_q    <= 1'b0;
      best_q        <= GESTURE_UP;
      score_q       <= '0;
    end else begin
      case (state_q)
        SCHED_IDLE: begin
          if (bus_if.start_v_i) begin
            state_q       <= SCHED_RUN;
            cnt_q         <= {SEQ_CNT_W{1'b0}};
            start_ready_q <= 1'b0;
            frame_busy_q  <= 1'b1;
          end
        end
        SCHED_RUN: begin
          // The counter wraps back to zero on the final pixel, leaving the ROM address parked at 0.
          cnt_q <= cnt_d;
          if (take_best_s) begin
            best_q  <= gesture_e'(gesture_s);
            score_q <= final_s;
          end
          if (last_gesture_s && last_pixel_s) begin
            state_q      <= SCHED_DONE;
            frame_busy_q <= 1'b0;
            result_v_q   <= 1'b1;
          end
        end
        SCHED_DONE: begin
          // Start requests are ignored here; start_ready only returns once the result is taken.
          if (bus_if.result_ready_i) begin
            state_q       <= SCHED_IDLE;
            result_v_q    <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= SCHED_IDLE;
          cnt_q         <= {SEQ_CNT_W{1'b0}};
          start_ready_q <= 1'b1;
          frame_busy_q  <= 1'b0;
          result_v_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.start_ready_o  = start_ready_q;
  assign bus_if.frame_busy_o   = frame_busy_q;
  assign bus_if.result_v_o     = result_v_q;
  assign bus_if.gesture_o      = cnt_q[SEQ_CNT_W-1 -: GESTURE_W];
  assign bus_if.pixel_addr_o   = cnt_q[PIXEL_ADDR_W-1:0];
  assign bus_if.gesture_o_best = best_q;
  assign bus_if.score_o        = score_q;

endmodule

// File: tb/tb_matmul_gesture_sched.sv
// Self-checking bench for matmul_gesture_sched: directed frames with a directional
// weight ROM plus random frames/ROMs, all scored by a plain-arithmetic reference model.
module tb_matmul_gesture_sched;

  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  matmul_gesture_sched_if #(
    .COUNTER_WIDTH_P (8),
    .PIXEL_WIDTH_P   (8),
    .ACC_WIDTH_P     (AW)
  ) bus_if ();

  matmul_gesture_sched #(
    .WIDTH_P         (8),
    .HEIGHT_P        (8),
    .COUNTER_WIDTH_P (8),
    .PIXEL_WIDTH_P   (8),
    .ACC_WIDTH_P     (AW)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus_if)
  );

  logic signed [7:0] rom   [0:3][0:63];
  logic        [7:0] frame [0:63];

  int n_checks = 0;
  int n_errors = 0;

  // Combinational weight ROM and frame buffer, addressed by the DUT.
  assign bus_if.weight_i = rom[bus_if.gesture_o][bus_if.pixel_addr_o];
  assign bus_if.pixel_i  = frame[bus_if.pixel_addr_o];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: four dot products, then the first strictly-largest score wins.
  task automatic model(output int best, output int score);
    int s [4];
    for (int g = 0; g < 4; g++) begin
      s[g] = 0;
      for (int p = 0; p < 64; p++) s[g] += int'(rom[g][p]) * int'(frame[p]);
    end
    best  = 0;
    score = s[0];
    for (int g = 1; g < 4; g++) begin
      if (s[g] > score) begin
        best  = g;
        score = s[g];
      end
    end
  endtask

  task automatic load_rom_directional();
    for (int p = 0; p < 64; p++) begin
      rom[0][p] = ((p / 8) < 4) ? 8'sd2 : -8'sd2;
      rom[1][p] = ((p / 8) < 4) ? -8'sd2 : 8'sd2;
      rom[2][p] = ((p % 8) < 4) ? 8'sd2 : -8'sd2;
      rom[3][p] = ((p % 8) < 4) ? -8'sd2 : 8'sd2;
    end
  endtask

  // Weights limited to [-32, 31] so the 20-bit score cannot overflow.
  task automatic load_rom_random();
    int v;
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 64; p++) begin
        v = int'($urandom_range(63, 0)) - 32;
        rom[g][p] = 8'(v);
      end
    end
  endtask

  task automatic load_frame_random();
    for (int p = 0; p < 64; p++) frame[p] = 8'($urandom_range(255, 0));
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk);
    check({tag, "_ready_idle"}, int'(bus_if.start_ready_o), 1);
    bus_if.start_v_i = 1'b1;
    @(negedge clk);
    bus_if.start_v_i = 1'b0;
    check({tag, "_busy_run"}, int'(bus_if.frame_busy_o), 1);
    check({tag, "_ready_run"}, int'(bus_if.start_ready_o), 0);
    check({tag, "_addr0"}, int'(bus_if.pixel_addr_o), 0);
  endtask

  // Counts negedges after acceptance until result_v; bounded at 400.
  task automatic wait_result(input string tag, output int cyc);
    cyc = 0;
    while (bus_if.result_v_o !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 100) begin
        check({tag, "_gesture_c100"}, int'(bus_if.gesture_o), 1);
        check({tag, "_addr_c100"}, int'(bus_if.pixel_addr_o), 36);
      end
    end
  endtask

  task automatic accept_result(input string tag);
    bus_if.result_ready_i = 1'b1;
    @(negedge clk);
    bus_if.result_ready_i = 1'b0;
    check({tag, "_v_after_hs"}, int'(bus_if.result_v_o), 0);
    check({tag, "_ready_after_hs"}, int'(bus_if.start_ready_o), 1);
  endtask

  task automatic run_and_check(input string tag, input int eb, input int es);
    int cyc;
    start_frame(tag);
    wait_result(tag, cyc);
    check({tag, "_latency"}, cyc, 256);
    check({tag, "_best"}, int'(bus_if.gesture_o_best), eb);
    check({tag, "_score"}, int'(bus_if.score_o), es);
    accept_result(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, es, eb2, es2, cyc, rises, first_at, second_at;

    rst = 1'b1;
    bus_if.start_v_i      = 1'b0;
    bus_if.result_ready_i = 1'b0;
    for (int p = 0; p < 64; p++) frame[p] = 8'd0;
    load_rom_directional();
    repeat (2) @(negedge clk);
    check("rst_start_ready", int'(bus_if.start_ready_o), 1);
    check("rst_busy", int'(bus_if.frame_busy_o), 0);
    check("rst_result_v", int'(bus_if.result_v_o), 0);
    check("rst_gesture", int'(bus_if.gesture_o), 0);
    check("rst_addr", int'(bus_if.pixel_addr_o), 0);
    check("rst_best", int'(bus_if.gesture_o_best), 0);
    check("rst_score", int'(bus_if.score_o), 0);
    rst = 1'b0;

    // All-zero frame: every score ties at 0, UP wins.
    run_and_check("zero", 0, 0);

    // Top half bright: UP dominates.
    for (int p = 0; p < 64; p++) frame[p] = ((p / 8) < 4) ? 8'd255 : 8'd0;
    run_and_check("rows", 0, 16320);

    // Right half lit: RIGHT dominates.
    for (int p = 0; p < 64; p++) frame[p] = ((p % 8) >= 4) ? 8'd10 : 8'd0;
    run_and_check("cols", 3, 640);

    // Consumer stalls while a spurious start is pulsed.
    start_frame("stall");
    wait_result("stall", cyc);
    check("stall_latency", cyc, 256);
    for (int i = 0; i < 10; i++) begin
      bus_if.start_v_i = (i == 3);
      @(negedge clk);
      check("stall_v", int'(bus_if.result_v_o), 1);
      check("stall_start_ready", int'(bus_if.start_ready_o), 0);
      check("stall_busy", int'(bus_if.frame_busy_o), 0);
      check("stall_best", int'(bus_if.gesture_o_best), 3);
      check("stall_score", int'(bus_if.score_o), 640);
    end
    bus_if.start_v_i = 1'b0;
    accept_result("stall");
    check("stall_idle_busy", int'(bus_if.frame_busy_o), 0);

    // Reset in the middle of a run aborts it without a result.
    for (int p = 0; p < 64; p++) frame[p] = ((p / 8) < 4) ? 8'd255 : 8'd0;
    start_frame("abort");
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_start_ready", int'(bus_if.start_ready_o), 1);
    check("abort_busy", int'(bus_if.frame_busy_o), 0);
    check("abort_result_v", int'(bus_if.result_v_o), 0);
    check("abort_addr", int'(bus_if.pixel_addr_o), 0);
    @(negedge clk);
    rst = 1'b0;
    rises = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus_if.result_v_o === 1'b1) rises++;
    end
    check("abort_no_result", rises, 0);
    run_and_check("abort_rerun", 0, 16320);

    // Back-to-back frames with start held and ready tied high; frame swapped while DONE.
    load_rom_random();
    load_frame_random();
    model(eb, es);
    eb2 = -1;
    es2 = 0;
    @(negedge clk);
    bus_if.result_ready_i = 1'b1;
    bus_if.start_v_i      = 1'b1;
    @(negedge clk);
    cyc       = 0;
    first_at  = -1;
    second_at = -1;
    while (second_at < 0 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (bus_if.result_v_o === 1'b1) begin
        if (first_at < 0) begin
          first_at = cyc;
          check("b2b_best1", int'(bus_if.gesture_o_best), eb);
          check("b2b_score1", int'(bus_if.score_o), es);
          load_frame_random();
          model(eb2, es2);
        end else begin
          second_at = cyc;
          bus_if.start_v_i = 1'b0;
          check("b2b_best2", int'(bus_if.gesture_o_best), eb2);
          check("b2b_score2", int'(bus_if.score_o), es2);
        end
      end
    end
    bus_if.start_v_i = 1'b0;
    check("b2b_first_latency", first_at, 256);
    check("b2b_gap", second_at - first_at, 258);
    @(negedge clk);
    bus_if.result_ready_i = 1'b0;
    check("b2b_v_after", int'(bus_if.result_v_o), 0);
    check("b2b_idle_ready", int'(bus_if.start_ready_o), 1);

    // Random frames and ROMs against the reference model.
    for (int t = 0; t < 4; t++) begin
      load_rom_random();
      load_frame_random();
      model(eb, es);
      run_and_check($sformatf("rand%0d", t), eb, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
